quadratic_host_ctrl: RTL and testbench
======================================

// Module: quadratic_host_ctrl
// PURPOSE
//  Initiator for the quadratic_sequence strobe interface. Accepts one coefficient set
//  (a,b,c) over a valid/ready handshake and writes it serially to the solver with
//  write strobes. It waits for the solve, then issues two read strobes to fetch x1/x2.
//  It returns result code and roots over a second valid/ready handshake. Sits between
//  the AXI4-Lite register bank and the solver.
// PARAMETERS
//  GAP_CYCLES   1   idle cycles (write_en low) after each of the a and b writes; >=1
//  WAIT_CYCLES  11  idle cycles after the c write before i_result is sampled; >=1
//  READ_LAT     1   idle cycles after each read strobe before i_data is sampled; >=1
// PORTS
//  i_clk          in   1  clock, rising edge
//  i_rst_n        in   1  asynchronous active-low reset
//  i_start_valid  in   1  host request valid
//  o_start_ready  out  1  high only in IDLE; request accepted when valid&ready at an edge
//  i_coef_a/b/c   in   5  signed coefficients, latched on accept
//  o_done_valid   out  1  results valid; held until accepted
//  i_done_ready   in   1  host accepts results when valid&ready at an edge
//  o_result_code  out  2  raw solver o_result captured at end of WAIT
//  o_x1, o_x2     out  4  signed roots captured from solver o_data
//  o_busy         out  1  high in every state except IDLE
//  o_write_en     out  1  to solver i_write_en, one-cycle pulses
//  o_data         out  5  to solver i_data; coefficient during write cycle, else 0
//  o_read_en      out  1  to solver i_read_en, one-cycle pulses
//  i_result       in   2  from solver o_result
//  i_data         in   4  from solver o_data (signed)
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE. All registered outputs are 0:
//    write_en, read_en, data, done_valid, result_code, x1, x2 and busy. start_ready=1.
//  - All solver-side outputs are registered. No combinational path from i_* to o_*,
//    except o_start_ready, which decodes state.
//  - FSM: IDLE -> WR_A -> GAP_A -> WR_B -> GAP_B -> WR_C -> WAIT -> RD_X1 -> CAP_X1
//    -> RD_X2 -> CAP_X2 -> DONE -> IDLE.
//  - WR_*: 1 cycle, write_en=1, data=coef. GAP_*: GAP_CYCLES cycles, write_en=0, data=0.
//  - WAIT: WAIT_CYCLES cycles. i_result is latched into result_code on the exiting edge.
//  - RD_Xn: 1 cycle, read_en=1. CAP_Xn: READ_LAT cycles. i_data is latched into o_xn
//    on the exiting edge.
//  - A single down-counter, sized for max(GAP,WAIT,READ_LAT), times GAP/WAIT/CAP.
//    It reloads on each state entry.
//  - Latency: accept edge E0 to DONE entry = 5+2*GAP+WAIT+2*READ_LAT edges.
//    That is 20 with defaults. done_valid rises at E20.
//  - DONE: done_valid=1 with result_code/x1/x2 stable. On the valid&ready edge,
//    done_valid goes to 0 and the FSM returns to IDLE. If ready is already high,
//    done_valid is a 1-cycle pulse.
//  - start_valid outside IDLE is ignored, not queued. A new accept is possible on the
//    first IDLE cycle after DONE.
//  - Coefficient input changes after accept have no effect. result_code/x1/x2 keep
//    their last values until overwritten by the next capture.
//  - Both reads always occur, regardless of result_code. Roots are passed through
//    unmodified (4-bit two's complement).
//  - Reset mid-operation aborts the transaction. No strobe completes after reset
//    assertion. Nothing resumes after release.
// TESTING (bench uses a behavioural solver stub returning programmed result/roots)
//  1 a=1,b=2,c=1; stub result=2'b11, x1=x2=-1 -> o_data 5'd1,5'd2,5'd1 on write cycles;
//    o_result_code=11, o_x1=o_x2=4'b1111.
//  2 a=1,b=0,c=-4; stub x1=2, x2=-2 -> third write o_data=5'b11100;
//    o_x1=4'b0010, o_x2=4'b1110.
//  3 Timing, defaults -> write_en high in cycles 1,3,5 after E0. read_en high in
//    cycles 17,19. done_valid rises at E20. busy=1 from E0 until exit from DONE.
//  4 Hold i_done_ready=0 for 5 cycles in DONE and pulse i_start_valid -> outputs stable,
//    start_ready=0, request ignored. Ready=1 -> IDLE next cycle.
//  5 Assert i_rst_n=0 during WAIT -> all outputs 0 immediately. After release, a new
//    request completes a full 20-cycle transaction with correct values.
//  6 i_start_valid and i_done_ready tied high, two requests back-to-back ->
//    1-cycle done pulses. Second accept on the first IDLE cycle. No strobe overlap.

Source files
------------

// File: rtl/quadratic_host_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : quadratic_host_ctrl_if
//  Description : Bundles the host-side valid/ready handshakes and the
//                solver-side strobe bus of quadratic_host_ctrl.
//                master : the controller (drives o_* signals)
//                slave  : the surrounding host + solver (drives i_* signals)
//  Ports       : none (signal bundle only)
//  Revision    : 1.0  initial release
// ============================================================================
interface quadratic_host_ctrl_if;
  // host request side
  logic       i_start_valid;
  logic       o_start_ready;
  logic [4:0] i_coef_a;
  logic [4:0] i_coef_b;
  logic [4:0] i_coef_c;
  // host response side
  logic       o_done_valid;
  logic       i_done_ready;
  logic [1:0] o_result_code;
  logic [3:0] o_x1;
  logic [3:0] o_x2;
  logic       o_busy;
  // solver strobe side
  logic       o_write_en;
  logic [4:0] o_data;
  logic       o_read_en;
  logic [1:0] i_result;
  logic [3:0] i_data;

  modport master (
    input  i_start_valid, i_coef_a, i_coef_b, i_coef_c, i_done_ready,
    input  i_result, i_data,
    output o_start_ready, o_done_valid, o_result_code, o_x1, o_x2, o_busy,
    output o_write_en, o_data, o_read_en
  );

  modport slave (
    output i_start_valid, i_coef_a, i_coef_b, i_coef_c, i_done_ready,
    output i_result, i_data,
    input  o_start_ready, o_done_valid, o_result_code, o_x1, o_x2, o_busy,
    input  o_write_en, o_data, o_read_en
  );
endinterface
`default_nettype wire

// File: rtl/quadratic_host_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : quadratic_host_ctrl
//  Description : Initiator for the quadratic solver strobe interface. Accepts
//                one (a,b,c) set, writes it serially with write strobes,
//                waits for the solve, reads x1/x2 with read strobes and
//                returns result code + roots over a valid/ready handshake.
//  Ports       : i_clk   - clock, rising edge
//                i_rst_n - asynchronous active-low reset
//                bus     - quadratic_host_ctrl_if.master (host handshakes
//                          and solver strobe bus)
//  Revision    : 1.0  initial release
// ============================================================================
module quadratic_host_ctrl #(
  parameter int GAP_CYCLES  = 1,
  parameter int WAIT_CYCLES = 11,
  parameter int READ_LAT    = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  quadratic_host_ctrl_if.master       bus
);

  localparam int MAX_A   = (GAP_CYCLES > WAIT_CYCLES) ? GAP_CYCLES : WAIT_CYCLES;
  localparam int MAX_CNT = (MAX_A > READ_LAT) ? MAX_A : READ_LAT;
  // counter only ever holds (N-1), so clog2(MAX) bits suffice
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] C_GAP_LD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_WAIT_LD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_READ_LD = CNT_W'(READ_LAT - 1);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_WR_A   = 4'd1;
  localparam logic [3:0] S_GAP_A  = 4'd2;
  localparam logic [3:0] S_WR_B   = 4'd3;
  localparam logic [3:0] S_GAP_B  = 4'd4;
  localparam logic [3:0] S_WR_C   = 4'd5;
  localparam logic [3:0] S_WAIT   = 4'd6;
  localparam logic [3:0] S_RD_X1  = 4'd7;
  localparam logic [3:0] S_CAP_X1 = 4'd8;
  localparam logic [3:0] S_RD_X2  = 4'd9;
  localparam logic [3:0] S_CAP_X2 = 4'd10;
  localparam logic [3:0] S_DONE   = 4'd11;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       coef_b_q, coef_b_d;
  logic [4:0]       coef_c_q, coef_c_d;

  logic             write_en_q, write_en_d;
  logic [4:0]       data_q, data_d;
  logic             read_en_q, read_en_d;
  logic             done_valid_q, done_valid_d;
  logic             busy_q, busy_d;
  logic [1:0]       result_code_q, result_code_d;
  logic [3:0]       x1_q, x1_d;
  logic [3:0]       x2_q, x2_d;

  logic             cnt_zero;
  assign cnt_zero = (cnt_q == '0);

  // --------------------------------------------------------------------------
  // State register (also holds the registered outputs)
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      coef_b_q      <= '0;
      coef_c_q      <= '0;
      write_en_q    <= 1'b0;
      data_q        <= '0;
      read_en_q     <= 1'b0;
      done_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      result_code_q <= '0;
      x1_q          <= '0;
      x2_q          <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      coef_b_q      <= coef_b_d;
      coef_c_q      <= coef_c_d;
      write_en_q    <= write_en_d;
      data_q        <= data_d;
      read_en_q     <= read_en_d;
      done_valid_q  <= done_valid_d;
      busy_q        <= busy_d;
      result_code_q <= result_code_d;
      x1_q          <= x1_d;
      x2_q          <= x2_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic. Timed states exit when the counter reaches zero; the
  // counter is reloaded on the transition into each timed state.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    coef_b_d = coef_b_q;
    coef_c_d = coef_c_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_start_valid) begin
          state_d  = S_WR_A;
          // a is written on the very next cycle straight from the input;
          // only b and c need holding
          coef_b_d = bus.i_coef_b;
          coef_c_d = bus.i_coef_c;
        end
      end
      S_WR_A: begin
        state_d = S_GAP_A;
        cnt_d   = C_GAP_LD;
      end
      S_GAP_A: begin
        if (cnt_zero) state_d = S_WR_B;
        else          cnt_d   = cnt_q - CNT_W'(1);
      end
      S_WR_B: begin
        state_d = S_GAP_B;
        cnt_d   = C_GAP_LD;
      end
      S_GAP_B: begin
        if (cnt_zero) state_d = S_WR_C;
        else          cnt_d   = cnt_q - CNT_W'(1);
      end
      S_WR_C: begin
        state_d = S_WAIT;
        cnt_d   = C_WAIT_LD;
      end
      S_WAIT: begin
        if (cnt_zero) state_d = S_RD_X1;
        else          cnt_d   = cnt_q - CNT_W'(1);
      end
      S_RD_X1: begin
        state_d = S_CAP_X1;
        cnt_d   = C_READ_LD;
      end
      S_CAP_X1: begin
        if (cnt_zero) state_d = S_RD_X2;
        else          cnt_d   = cnt_q - CNT_W'(1);
      end
      S_RD_X2: begin
        state_d = S_CAP_X2;
        cnt_d   = C_READ_LD;
      end
      S_CAP_X2: begin
        if (cnt_zero) state_d = S_DONE;
        else          cnt_d   = cnt_q - CNT_W'(1);
      end
      S_DONE: begin
        if (bus.i_done_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic. Strobes and status are decoded from the *next* state so the
  // registered outputs line up with the state they belong to. Captures happen
  // on the edge leaving WAIT / CAP_Xn.
  // --------------------------------------------------------------------------
  always_comb begin
    write_en_d    = (state_d == S_WR_A) || (state_d == S_WR_B) || (state_d == S_WR_C);
    read_en_d     = (state_d == S_RD_X1) || (state_d == S_RD_X2);
    done_valid_d  = (state_d == S_DONE);
    busy_d        = (state_d != S_IDLE);
    data_d        = '0;
    case (state_d)
      S_WR_A:  data_d = bus.i_coef_a;
      S_WR_B:  data_d = coef_b_q;
      S_WR_C:  data_d = coef_c_q;
      default: data_d = '0;
    endcase
    result_code_d = result_code_q;
    x1_d          = x1_q;
    x2_d          = x2_q;
    if ((state_q == S_WAIT)   && cnt_zero) result_code_d = bus.i_result;
    if ((state_q == S_CAP_X1) && cnt_zero) x1_d          = bus.i_data;
    if ((state_q == S_CAP_X2) && cnt_zero) x2_d          = bus.i_data;
  end

  assign bus.o_start_ready = (state_q == S_IDLE);
  assign bus.o_write_en    = write_en_q;
  assign bus.o_data        = data_q;
  assign bus.o_read_en     = read_en_q;
  assign bus.o_done_valid  = done_valid_q;
  assign bus.o_busy        = busy_q;
  assign bus.o_result_code = result_code_q;
  assign bus.o_x1          = x1_q;
  assign bus.o_x2          = x2_q;

endmodule
`default_nettype wire

// File: tb/tb_quadratic_host_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_quadratic_host_ctrl
//  Description : Self-checking bench for quadratic_host_ctrl with a solver
//                stub returning programmed result/roots.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_quadratic_host_ctrl;

  localparam int G  = 1;
  localparam int W  = 11;
  localparam int RL = 1;
  localparam int L  = 5 + 2*G + W + 2*RL;   // accept edge to DONE entry

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  int         n_tests = 0;
  int         n_fail  = 0;

  logic [1:0] stub_res = '0;
  logic [3:0] stub_x1  = '0;
  logic [3:0] stub_x2  = '0;
  logic       rd_idx;
  logic [3:0] sol_data;

  quadratic_host_ctrl_if bus();

  quadratic_host_ctrl #(
    .GAP_CYCLES  (G),
    .WAIT_CYCLES (W),
    .READ_LAT    (RL)
  ) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // solver stub: result is static, each read strobe presents the next root
  assign bus.i_result = stub_res;
  assign bus.i_data   = sol_data;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx   <= 1'b0;
      sol_data <= '0;
    end else if (bus.o_read_en) begin
      sol_data <= rd_idx ? stub_x2 : stub_x1;
      rd_idx   <= ~rd_idx;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_we"},    32'(bus.o_write_en),    32'd0);
    chk({tag, "_re"},    32'(bus.o_read_en),     32'd0);
    chk({tag, "_data"},  32'(bus.o_data),        32'd0);
    chk({tag, "_dv"},    32'(bus.o_done_valid),  32'd0);
    chk({tag, "_rc"},    32'(bus.o_result_code), 32'd0);
    chk({tag, "_x1"},    32'(bus.o_x1),          32'd0);
    chk({tag, "_x2"},    32'(bus.o_x2),          32'd0);
    chk({tag, "_busy"},  32'(bus.o_busy),        32'd0);
    chk({tag, "_sr"},    32'(bus.o_start_ready), 32'd1);
  endtask

  // One full transaction, entered and left at a negedge with the DUT idle.
  // b2b keeps start_valid high so the next call accepts on the first IDLE cycle.
  task automatic run_txn(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                         input logic [1:0] res, input logic [3:0] r1, input logic [3:0] r2,
                         input int rdy_delay, input bit b2b);
    logic       exp_we;
    logic       exp_re;
    logic [4:0] exp_data;
    stub_res = res;
    stub_x1  = r1;
    stub_x2  = r2;
    bus.i_coef_a = a;
    bus.i_coef_b = b;
    bus.i_coef_c = c;
    bus.i_start_valid = 1'b1;
    chk("start_ready_idle", 32'(bus.o_start_ready), 32'd1);
    @(posedge clk);   // accept edge E0
    @(negedge clk);
    if (!b2b) begin
      bus.i_start_valid = 1'b0;
      // later coefficient changes must not reach the solver
      bus.i_coef_a = 5'($urandom);
      bus.i_coef_b = 5'($urandom);
      bus.i_coef_c = 5'($urandom);
    end
    for (int k = 1; k <= L; k++) begin
      if (k > 1) @(negedge clk);
      exp_we   = (k == 1) || (k == 2 + G) || (k == 3 + 2*G);
      exp_data = (k == 1) ? a : (k == 2 + G) ? b : (k == 3 + 2*G) ? c : 5'd0;
      exp_re   = (k == 4 + 2*G + W) || (k == 5 + 2*G + W + RL);
      chk("write_en",   32'(bus.o_write_en),    32'(exp_we));
      chk("data",       32'(bus.o_data),        32'(exp_data));
      chk("read_en",    32'(bus.o_read_en),     32'(exp_re));
      chk("busy",       32'(bus.o_busy),        32'd1);
      chk("done_early", 32'(bus.o_done_valid),  32'd0);
      chk("start_rdy",  32'(bus.o_start_ready), 32'd0);
    end
    @(negedge clk);   // first DONE cycle
    chk("done_valid", 32'(bus.o_done_valid),  32'd1);
    chk("done_busy",  32'(bus.o_busy),        32'd1);
    chk("done_sr",    32'(bus.o_start_ready), 32'd0);
    chk("result",     32'(bus.o_result_code), 32'(res));
    chk("x1",         32'(bus.o_x1),          32'(r1));
    chk("x2",         32'(bus.o_x2),          32'(r2));
    chk("done_we",    32'(bus.o_write_en),    32'd0);
    chk("done_re",    32'(bus.o_read_en),     32'd0);
    for (int d = 0; d < rdy_delay; d++) begin
      bus.i_done_ready  = 1'b0;
      bus.i_start_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("hold_dv",     32'(bus.o_done_valid),  32'd1);
      chk("hold_sr",     32'(bus.o_start_ready), 32'd0);
      chk("hold_result", 32'(bus.o_result_code), 32'(res));
      chk("hold_x1",     32'(bus.o_x1),          32'(r1));
      chk("hold_x2",     32'(bus.o_x2),          32'(r2));
      chk("hold_we",     32'(bus.o_write_en),    32'd0);
    end
    bus.i_done_ready  = 1'b1;
    bus.i_start_valid = b2b;
    @(negedge clk);   // first IDLE cycle
    chk("exit_dv",   32'(bus.o_done_valid),  32'd0);
    chk("exit_busy", 32'(bus.o_busy),        32'd0);
    chk("exit_sr",   32'(bus.o_start_ready), 32'd1);
    chk("keep_x1",   32'(bus.o_x1),          32'(r1));
    if (!b2b) begin
      bus.i_done_ready = 1'b0;
      @(negedge clk);
      chk("no_queue_busy", 32'(bus.o_busy),     32'd0);
      chk("no_queue_we",   32'(bus.o_write_en), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_start_valid = 1'b0;
    bus.i_done_ready  = 1'b0;
    bus.i_coef_a      = '0;
    bus.i_coef_b      = '0;
    bus.i_coef_c      = '0;
    repeat (2) @(negedge clk);
    chk_reset_state("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // 1: double root at -1
    run_txn(5'd1, 5'd2, 5'd1, 2'b11, 4'b1111, 4'b1111, 1, 1'b0);
    // 2: roots +2/-2, negative c
    run_txn(5'd1, 5'd0, 5'b11100, 2'b01, 4'b0010, 4'b1110, 0, 1'b0);
    // 4: done held for 5 cycles with stray start pulses
    run_txn(5'd3, 5'd7, 5'd9, 2'b10, 4'd5, 4'd9, 5, 1'b0);

    // 5: reset during WAIT aborts
    stub_res = 2'b10; stub_x1 = 4'd3; stub_x2 = 4'd4;
    bus.i_coef_a = 5'd4; bus.i_coef_b = 5'd5; bus.i_coef_c = 5'd6;
    bus.i_start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_start_valid = 1'b0;
    repeat (9) @(negedge clk);   // cycle 10, inside WAIT
    chk("pre_rst_busy", 32'(bus.o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_state("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_busy", 32'(bus.o_busy),     32'd0);
      chk("post_rst_we",   32'(bus.o_write_en), 32'd0);
      chk("post_rst_re",   32'(bus.o_read_en),  32'd0);
    end
    run_txn(5'd2, 5'd30, 5'd17, 2'b01, 4'd7, 4'd8, 0, 1'b0);

    // 6: back-to-back with valid/ready tied high
    bus.i_done_ready = 1'b1;
    run_txn(5'd11, 5'd12, 5'd13, 2'b11, 4'd1, 4'd14, 0, 1'b1);
    run_txn(5'd21, 5'd22, 5'd23, 2'b00, 4'd6, 4'd10, 0, 1'b0);

    // randomized transactions
    for (int i = 0; i < 20; i++) begin
      run_txn(5'($urandom), 5'($urandom), 5'($urandom), 2'($urandom),
              4'($urandom), 4'($urandom), int'($urandom_range(0, 3)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
